pulse_meter: RTL and testbench



---
 rtl/pulse_meter.sv | 91 +++++++++
 tb/tb_pulse_meter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Measures the width of each high pulse on `in` and hands it off as a byte over dav_z_/rfd_z.
// Latency: z/dav_z_ update on the first edge that samples `in` low after a pulse.
// Backpressure: a pulse starting before the handshake completes is flagged on `lost` and skipped.
module pulse_meter (
    input  logic       clock,
    input  logic       reset_,
    input  logic       in,
    output logic [7:0] z,
    output logic       dav_z_,
    input  logic       rfd_z,
    output logic       lost
);

    typedef enum logic [2:0] {
        SKIP,
        IDLE,
        COUNT,
        WAIT_ACK,
        WAIT_RFD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] z_nxt;
    logic       dav_nxt;
    logic       lost_nxt;
    logic       in_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        z_nxt     = z;
        dav_nxt   = dav_z_;
        lost_nxt  = 1'b0;
        case (state)
            SKIP: begin
                if (!in) state_nxt = IDLE;
            end
            IDLE: begin
                if (in) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (in) begin
                    // Saturate rather than wrap so very long pulses read as 255.
                    if (cnt != 8'hFF) cnt_nxt = cnt + 8'd1;
                end else begin
                    z_nxt     = cnt;
                    dav_nxt   = 1'b0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                lost_nxt = in & ~in_q;
                if (!rfd_z) begin
                    dav_nxt   = 1'b1;
                    state_nxt = WAIT_RFD;
                end
            end
            WAIT_RFD: begin
                lost_nxt = in & ~in_q;
                // A pulse still high here was already reported lost; drop its tail.
                if (rfd_z) state_nxt = in ? SKIP : IDLE;
            end
            default: state_nxt = SKIP;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state  <= SKIP;
            cnt    <= 8'd0;
            z      <= 8'd0;
            dav_z_ <= 1'b1;
            lost   <= 1'b0;
            in_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            z      <= z_nxt;
            dav_z_ <= dav_nxt;
            lost   <= lost_nxt;
            in_q   <= in;
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: table of directed widths, hand-written lost/reset sequences, random pulses vs a width model.
module tb_pulse_meter;

    logic       clock;
    logic       reset_;
    logic       in;
    logic [7:0] z;
    logic       dav_z_;
    logic       rfd_z;
    logic       lost;

    int n_cmp;
    int n_bad;
    int lost_seen;

    pulse_meter dut (
        .clock  (clock),
        .reset_ (reset_),
        .in     (in),
        .z      (z),
        .dav_z_ (dav_z_),
        .rfd_z  (rfd_z),
        .lost   (lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (lost === 1'b1) lost_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int width;
        int ack_delay;
        int exp_z;
    } vec_t;

    function automatic int model_width(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int sel_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full pulse plus handshake; ack_delay = extra cycles dav_z_ stays low.
    task automatic measure(input int width, input int ack_delay, input int exp_z);
        rfd_z = (ack_delay == 0) ? 1'b0 : 1'b1;
        in    = 1'b1;
        repeat (width) tick();
        check("dav_high_during_pulse", {31'd0, dav_z_}, 32'd1);
        in = 1'b0;
        tick();
        check("dav_low_after_fall", {31'd0, dav_z_}, 32'd0);
        check("z_value", {24'd0, z}, exp_z);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check("dav_held", {31'd0, dav_z_}, 32'd0);
            check("z_held", {24'd0, z}, exp_z);
        end
        rfd_z = 1'b0;
        tick();
        check("dav_released", {31'd0, dav_z_}, 32'd1);
        check("z_after_ack", {24'd0, z}, exp_z);
        rfd_z = 1'b1;
        tick();
    endtask

    vec_t vecs[$];
    int   exp_q[$];

    initial begin
        int lost_base;
        int w;
        int a;

        n_cmp = 0;
        n_bad = 0;
        lost_seen = 0;

        vecs.push_back('{20, 3, 20});
        vecs.push_back('{1, 0, 1});
        vecs.push_back('{2, 1, 2});
        vecs.push_back('{15, 2, 15});
        vecs.push_back('{27, 0, 27});
        vecs.push_back('{300, 1, 255});
        vecs.push_back('{255, 0, 255});
        vecs.push_back('{256, 2, 255});
        vecs.push_back('{254, 1, 254});
        // Max-selector output pulses for (12,5), (5,15), (33,20).
        vecs.push_back('{sel_max(12, 5), 1, 12});
        vecs.push_back('{sel_max(5, 15), 2, 15});
        vecs.push_back('{sel_max(33, 20), 0, 33});

        reset_ = 1'b0;
        in     = 1'b0;
        rfd_z  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_z", {24'd0, z}, 32'd0);
        check("reset_dav", {31'd0, dav_z_}, 32'd1);
        check("reset_lost", {31'd0, lost}, 32'd0);
        reset_ = 1'b1;
        tick();

        foreach (vecs[i]) measure(vecs[i].width, vecs[i].ack_delay, vecs[i].exp_z);
        check("no_lost_in_table", lost_seen, 32'd0);

        // Pulse arrives while the consumer is still holding off the ack.
        lost_base = lost_seen;
        rfd_z = 1'b1;
        in = 1'b1;
        repeat (20) tick();
        in = 1'b0;
        tick();
        check("lost_first_dav", {31'd0, dav_z_}, 32'd0);
        tick();
        in = 1'b1;
        tick();
        check("lost_strobe", {31'd0, lost}, 32'd1);
        tick();
        check("lost_one_cycle", {31'd0, lost}, 32'd0);
        check("lost_first_z_kept", {24'd0, z}, 32'd20);
        tick();
        rfd_z = 1'b0;
        tick();
        check("lost_ack_dav", {31'd0, dav_z_}, 32'd1);
        rfd_z = 1'b1;
        repeat (6) tick();
        in = 1'b0;
        tick();
        check("lost_no_result", {31'd0, dav_z_}, 32'd1);
        check("lost_z_unchanged", {24'd0, z}, 32'd20);
        check("lost_count", lost_seen - lost_base, 32'd1);
        measure(12, 1, 12);

        // Reset in the middle of a 50-cycle pulse; its tail must be skipped.
        in = 1'b1;
        repeat (20) tick();
        reset_ = 1'b0;
        #1;
        check("midreset_dav", {31'd0, dav_z_}, 32'd1);
        check("midreset_z", {24'd0, z}, 32'd0);
        repeat (2) tick();
        reset_ = 1'b1;
        repeat (28) tick();
        in = 1'b0;
        tick();
        check("skip_no_result", {31'd0, dav_z_}, 32'd1);
        check("skip_z_zero", {24'd0, z}, 32'd0);
        measure(7, 2, 7);

        // Random widths and consumer delays against the width model.
        lost_base = lost_seen;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0) w = $urandom_range(240, 300);
            else w = $urandom_range(1, 40);
            a = $urandom_range(0, 4);
            exp_q.push_back(model_width(w));
            measure(w, a, exp_q.pop_front());
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("gap_dav", {31'd0, dav_z_}, 32'd1);
            end
        end
        check("random_no_lost", lost_seen - lost_base, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
